rpl_age_arbiter: RTL and testbench
==================================

Name: rpl_age_arbiter

Overview:
- Age-ordered lock arbiter for a shared resource pool, such as the ALU pool or the data-memory port.
- Requesters are SIC ports. Each presents a request plus its issue ID; the arbiter grants up to NUM_RES resource slots, oldest issue ID first.
- A slot stays locked to its holder until the holder drops its request.
- Sits between the SIC array and a pool datapath, which muxes operands by grant_slot.

Parameters:
- NUM_PORTS, 8, number of requesters (SICs).
- NUM_RES, 8, number of resource slots in the pool.
- ID_WIDTH, 16, issue ID width; IDs wrap modulo 2^ID_WIDTH.
- MAX_GRANTS_PER_CYCLE, 2, maximum new grants issued per clock edge (1..NUM_RES).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  rollback; drops every lock.
- req_valid  in  [NUM_PORTS]  port p requests or keeps holding a slot.
- req_id  in  [NUM_PORTS][ID_WIDTH]  issue ID of port p.
- grant  out  [NUM_PORTS]  port p holds a slot.
- grant_slot  out  [NUM_PORTS][clog2(NUM_RES)]  slot held by port p; 0 when grant=0.
- slot_busy  out  [NUM_RES]  slot k is locked.
- free_count  out  clog2(NUM_RES+1)  number of unlocked slots.

Behaviour:
- Reset (rst_n=0, async):
  - grant=0, grant_slot=0, slot_busy=0, free_count=NUM_RES.
  - All latched IDs are cleared.
  - Reset mid-lock simply drops the lock; no release handshake is needed.
- All outputs are registered. The combinational allocator reads only the current registered state plus the inputs.
- Age order: a is older than b iff signed ID_WIDTH-bit (a-b) < 0. Equal IDs tie-break to the lower port index.
- Candidate: req_valid[p]=1 and grant[p]=0.
- Allocation at each edge:
  - N = min(free_count, MAX_GRANTS_PER_CYCLE, number of candidates).
  - The N oldest candidates are granted.
  - The i-th oldest candidate receives the i-th lowest-index free slot.
  - grant[p] rises the edge after req_valid rises (1-cycle latency) if port p is among the chosen.
- Per-port states: IDLE -> WAIT (req, no slot) -> HELD (grant=1).
  - IDLE to HELD directly when granted on the first sampled edge.
  - WAIT persists, re-arbitrated every cycle.
- Hold: while req_valid[p]=1 in HELD, the slot and latched ID are frozen. req_id changes are ignored.
- Release:
  - req_valid[p]=0 in HELD: at the next edge grant[p]=0, grant_slot[p]=0, and the slot frees.
  - The freed slot is not reallocated at that same edge; it becomes allocatable from the following edge.
  - req_valid[p]=0 in WAIT: returns to IDLE, no side effect.
- Same-cycle release and re-request by one port is impossible: the request must stay low for at least one edge.
- Full pool: free_count=0. All candidates wait. No preemption, even by an older ID.
- Wrap-around: comparison is modular. An ID of 0x0001 is younger than 0xFFFE.
  - Requirement: live IDs span less than 2^(ID_WIDTH-1).
- flush=1 at an edge:
  - All ports go to IDLE, slot_busy=0, free_count=NUM_RES.
  - No grants are issued at that edge, even if req_valid=1.
  - Requests still high after flush are re-arbitrated from the next edge.
- Invariants:
  - Each slot has at most one holder.
  - popcount(grant) = NUM_RES - free_count.
  - slot_busy[grant_slot[p]]=1 for every granted p.

Optional Feature:
- Macro: RPL_AGE_ARB_STATS_EN.
- Defined: adds outputs stat_grants (32b, grants issued), stat_wait_cycles (32b, sum over cycles of ports in WAIT) and stat_max_wait (16b, longest single WAIT run, saturating).
  - Counters reset to 0 on rst_n and are unaffected by flush.
  - stat_grants and stat_wait_cycles wrap.
- Undefined: these ports and counters are absent. Arbitration behaviour is identical either way.

Decomposition:
- Shared package rpl_arb_pkg holds:
  - function id_older(a,b) with ID_WIDTH as a parameter;
  - port-state enum {IDLE, WAIT, HELD};
  - slot-index width helper.
- One sub-module, rpl_oldest_picker: combinational, selects the oldest masked candidate and outputs a one-hot plus valid.
  - Instantiated MAX_GRANTS_PER_CYCLE times in cascade.
  - Each stage masks out the winners of earlier stages.

Test Plan:
- Reset, then req_valid=0xFF with ports 0..7 at IDs 10..17 (port p gets ID 10+p), MAX_GRANTS_PER_CYCLE=2, NUM_RES=8.
  - Edge 1 grants ports 0,1 (slots 0,1); edge 2 grants ports 2,3; free_count steps 8, 6, 4, 2, 0.
- NUM_RES=2, both slots held; port 5 (ID 3) and port 6 (ID 2) request.
  - Both wait. Port 0 drops its request: slot freed at edge t, port 6 granted the freed slot at edge t+1, port 5 still waiting.
- Wrap: port 1 ID=0xFFFE, port 2 ID=0x0001, one free slot -> port 1 granted first.
- Equal ID 0x0040 on ports 3 and 4, one slot -> port 3 granted; port 4 granted one edge after port 3 releases.
- Three ports HELD, flush pulse -> next edge grant=0, free_count=NUM_RES. Requests held high regain grants from the edge after.
- rst_n asserted asynchronously mid-cycle while locks are held -> outputs clear immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/rpl_arb_pkg.sv
// Shared types and helpers for the age-ordered lock arbiter.
// Holds the modular age comparison, the per-port state enum and the slot-index width helper.
package rpl_arb_pkg;

  localparam int ID_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } port_state_e;

  function automatic int slot_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // a is older than b when (a - b), read as a signed id_width-bit value, is negative.
  function automatic logic id_older(input logic [ID_MAX_W-1:0] a,
                                    input logic [ID_MAX_W-1:0] b,
                                    input int                  id_width);
    return ((a - b) & (ID_MAX_W'(1) << (id_width - 1))) != '0;
  endfunction

endpackage

// File: rtl/rpl_oldest_picker.sv
// Combinational oldest-candidate selector: one-hot of the oldest masked candidate plus valid.
// Equal IDs resolve to the lower port index, so the one-hot is always exact.
module rpl_oldest_picker
  import rpl_arb_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int ID_WIDTH  = 16
) (
  input  logic [NUM_PORTS-1:0]               cand,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] ids,
  output logic [NUM_PORTS-1:0]               onehot,
  output logic                               valid
);

  // NOTE: onehot gets its full value before the loop clears bits, so no path leaves it unassigned (no latch).
  always_comb begin
    onehot = cand;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (q != p && cand[q] &&
            (id_older(ID_MAX_W'(ids[q]), ID_MAX_W'(ids[p]), ID_WIDTH) ||
             (ids[q] == ids[p] && q < p))) begin
          onehot[p] = 1'b0;
        end
      end
    end
  end

  assign valid = |cand;

endmodule

// File: rtl/rpl_age_arbiter.sv
// Age-ordered lock arbiter: grants pool slots oldest-ID first, a slot stays locked until its holder drops req.
// Optional statistics outputs are enabled with `define RPL_AGE_ARB_STATS_EN.
module rpl_age_arbiter
  import rpl_arb_pkg::*;
#(
  parameter int NUM_PORTS            = 8,
  parameter int NUM_RES              = 8,
  parameter int ID_WIDTH             = 16,
  parameter int MAX_GRANTS_PER_CYCLE = 2,
  localparam int SLOT_W              = slot_idx_w(NUM_RES),
  localparam int CNT_W               = $clog2(NUM_RES + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [NUM_PORTS-1:0]               req_valid,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] req_id,
  output logic [NUM_PORTS-1:0]               grant,
  output logic [NUM_PORTS-1:0][SLOT_W-1:0]   grant_slot,
  output logic [NUM_RES-1:0]                 slot_busy,
  output logic [CNT_W-1:0]                   free_count
`ifdef RPL_AGE_ARB_STATS_EN
  ,
  output logic [31:0]                        stat_grants,
  output logic [31:0]                        stat_wait_cycles,
  output logic [15:0]                        stat_max_wait
`endif
);

  localparam int G = MAX_GRANTS_PER_CYCLE;

  port_state_e                        state   [NUM_PORTS];
  port_state_e                        state_n [NUM_PORTS];
  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] held_id, held_id_n, eff_id;
  logic [NUM_PORTS-1:0]               grant_n;
  logic [NUM_PORTS-1:0][SLOT_W-1:0]   grant_slot_n;
  logic [NUM_RES-1:0]                 slot_busy_n;
  logic [CNT_W-1:0]                   free_count_n;

  logic [NUM_PORTS-1:0]               cand;
  logic [G-1:0][NUM_PORTS-1:0]        remain;
  logic [G-1:0][NUM_PORTS-1:0]        pick;
  logic [G-1:0]                       pick_valid, free_ok, fire;
  logic [G-1:0][SLOT_W-1:0]           free_idx;
  int                                 nfree;

  assign cand      = req_valid & ~grant;
  assign remain[0] = cand;

  // Held ports present their frozen ID; they are never candidates, so this only keeps the ID visible.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_eff_id
    assign eff_id[p] = (state[p] == HELD) ? held_id[p] : req_id[p];
  end

  // Cascade: each stage picks the oldest among candidates not taken by earlier stages.
  for (genvar g = 0; g < G; g++) begin : g_stage
    rpl_oldest_picker #(
      .NUM_PORTS (NUM_PORTS),
      .ID_WIDTH  (ID_WIDTH)
    ) u_picker (
      .cand   (remain[g]),
      .ids    (eff_id),
      .onehot (pick[g]),
      .valid  (pick_valid[g])
    );
    if (g < G - 1) begin : g_mask
      assign remain[g+1] = remain[g] & ~pick[g];
    end
    assign fire[g] = pick_valid[g] & free_ok[g] & ~flush;
  end

  // The g-th lowest free slot feeds stage g; a slot freed this edge is still busy here.
  always_comb begin
    free_ok  = '0;
    free_idx = '0;
    nfree    = 0;
    for (int k = 0; k < NUM_RES; k++) begin
      if (!slot_busy[k]) begin
        for (int g = 0; g < G; g++) begin
          if (nfree == g) begin
            free_ok[g]  = 1'b1;
            free_idx[g] = SLOT_W'(k);
          end
        end
        nfree = nfree + 1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    held_id_n    = held_id;
    grant_n      = grant;
    grant_slot_n = grant_slot;
    slot_busy_n  = slot_busy;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (flush) begin
        state_n[p]      = IDLE;
        grant_n[p]      = 1'b0;
        grant_slot_n[p] = '0;
        held_id_n[p]    = '0;
      end else begin
        case (state[p])
          IDLE: if (req_valid[p])  state_n[p] = WAIT;
          WAIT: if (!req_valid[p]) state_n[p] = IDLE;
          HELD: begin
            if (!req_valid[p]) begin
              state_n[p]                  = IDLE;
              grant_n[p]                  = 1'b0;
              grant_slot_n[p]             = '0;
              held_id_n[p]                = '0;
              slot_busy_n[grant_slot[p]]  = 1'b0;
            end
          end
          default: state_n[p] = IDLE;
        endcase
      end
    end
    if (flush) slot_busy_n = '0;
    for (int g = 0; g < G; g++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (fire[g] && pick[g][p]) begin
          state_n[p]              = HELD;
          grant_n[p]              = 1'b1;
          grant_slot_n[p]         = free_idx[g];
          held_id_n[p]            = req_id[p];
          slot_busy_n[free_idx[g]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    free_count_n = '0;
    for (int k = 0; k < NUM_RES; k++) begin
      if (!slot_busy_n[k]) free_count_n = free_count_n + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) state[p] <= IDLE;
      // NOTE: the latched-ID array is flop-based, so it is cleared by reset like any other state.
      held_id    <= '0;
      grant      <= '0;
      grant_slot <= '0;
      slot_busy  <= '0;
      free_count <= CNT_W'(NUM_RES);
    end else begin
      state      <= state_n;
      held_id    <= held_id_n;
      grant      <= grant_n;
      grant_slot <= grant_slot_n;
      slot_busy  <= slot_busy_n;
      free_count <= free_count_n;
    end
  end

`ifdef RPL_AGE_ARB_STATS_EN
  logic [NUM_PORTS-1:0][15:0] wait_run, wait_run_n;
  logic [31:0]                grants_now, waits_now;
  logic [15:0]                max_now;

  always_comb begin
    grants_now = '0;
    waits_now  = '0;
    max_now    = stat_max_wait;
    wait_run_n = '0;
    for (int g = 0; g < G; g++) begin
      if (fire[g]) grants_now = grants_now + 32'd1;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (state[p] == WAIT) begin
        waits_now     = waits_now + 32'd1;
        wait_run_n[p] = (wait_run[p] == 16'hFFFF) ? wait_run[p] : wait_run[p] + 16'd1;
        if (wait_run_n[p] > max_now) max_now = wait_run_n[p];
      end
    end
  end

  // Counters ignore flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_run         <= '0;
      stat_grants      <= '0;
      stat_wait_cycles <= '0;
      stat_max_wait    <= '0;
    end else begin
      wait_run         <= wait_run_n;
      stat_grants      <= stat_grants + grants_now;
      stat_wait_cycles <= stat_wait_cycles + waits_now;
      stat_max_wait    <= max_now;
    end
  end
`endif

endmodule

// File: tb/tb_rpl_age_arbiter.sv
// Directed bench for rpl_age_arbiter: a vector table on the default 8-slot pool plus
// hand-written sequences on a 2-slot pool and an asynchronous mid-cycle reset.
module tb_rpl_age_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default pool: 8 ports, 8 slots, 2 grants per edge.
  logic             flush_a;
  logic [7:0]       req_valid_a;
  logic [7:0][15:0] req_id_a;
  logic [7:0]       grant_a;
  logic [7:0][2:0]  slot_a;
  logic [7:0]       busy_a;
  logic [3:0]       free_a;

  // Small pool: 8 ports, 2 slots.
  logic             flush_b;
  logic [7:0]       req_valid_b;
  logic [7:0][15:0] req_id_b;
  logic [7:0]       grant_b;
  logic [7:0][0:0]  slot_b;
  logic [1:0]       busy_b;
  logic [1:0]       free_b;

  rpl_age_arbiter u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush_a),
    .req_valid  (req_valid_a),
    .req_id     (req_id_a),
    .grant      (grant_a),
    .grant_slot (slot_a),
    .slot_busy  (busy_a),
    .free_count (free_a)
  );

  rpl_age_arbiter #(.NUM_RES(2)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush_b),
    .req_valid  (req_valid_b),
    .req_id     (req_id_b),
    .grant      (grant_b),
    .grant_slot (slot_b),
    .slot_busy  (busy_b),
    .free_count (free_b)
  );

  typedef struct {
    string        name;
    logic         flush;
    logic [7:0]   req_valid;
    logic [127:0] req_id;
    logic [7:0]   exp_grant;
    logic [23:0]  exp_slot;
    logic [7:0]   exp_busy;
    logic [3:0]   exp_free;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] ids8(input int i0, input int i1, input int i2, input int i3,
                                        input int i4, input int i5, input int i6, input int i7);
    return {16'(i7), 16'(i6), 16'(i5), 16'(i4), 16'(i3), 16'(i2), 16'(i1), 16'(i0)};
  endfunction

  function automatic logic [23:0] sl8(input int s0, input int s1, input int s2, input int s3,
                                      input int s4, input int s5, input int s6, input int s7);
    return {3'(s7), 3'(s6), 3'(s5), 3'(s4), 3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  task automatic add(input string name, input logic fl, input logic [7:0] rv, input logic [127:0] ids,
                     input logic [7:0] eg, input logic [23:0] es, input logic [7:0] eb, input logic [3:0] ef);
    vec_t v;
    v.name = name; v.flush = fl; v.req_valid = rv; v.req_id = ids;
    v.exp_grant = eg; v.exp_slot = es; v.exp_busy = eb; v.exp_free = ef;
    vecs.push_back(v);
  endtask

  task automatic drive_b(input logic [7:0] rv, input logic [127:0] ids);
    req_valid_b = rv;
    req_id_b    = ids;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] base, tie_ids, tie_ids2;
    base     = ids8(10, 11, 12, 13, 14, 15, 16, 17);
    tie_ids  = ids8(0, 0, 0, 'h40, 'h40, 0, 0, 'h30);
    tie_ids2 = ids8(0, 0, 0, 'h40, 'h40, 0, 0, 'h01);

    add("fill1",      0, 8'hFF, base, 8'h03, sl8(0,1,0,0,0,0,0,0), 8'h03, 4'd6);
    add("fill2",      0, 8'hFF, base, 8'h0F, sl8(0,1,2,3,0,0,0,0), 8'h0F, 4'd4);
    add("fill3",      0, 8'hFF, base, 8'h3F, sl8(0,1,2,3,4,5,0,0), 8'h3F, 4'd2);
    add("fill4",      0, 8'hFF, base, 8'hFF, sl8(0,1,2,3,4,5,6,7), 8'hFF, 4'd0);
    add("drop_all",   0, 8'h00, base, 8'h00, 24'd0,                8'h00, 4'd8);
    add("wrap",       0, 8'h06, ids8(0,'hFFFE,'h0001,0,0,0,0,0),
                                       8'h06, sl8(0,0,1,0,0,0,0,0), 8'h03, 4'd6);
    add("wrap_drop",  0, 8'h00, base, 8'h00, 24'd0,                8'h00, 4'd8);
    add("tie",        0, 8'h98, tie_ids,  8'h88, sl8(0,0,0,1,0,0,0,0), 8'h03, 4'd6);
    add("tie2",       0, 8'h98, tie_ids,  8'h98, sl8(0,0,0,1,2,0,0,0), 8'h07, 4'd5);
    add("hold_id",    0, 8'h98, tie_ids2, 8'h98, sl8(0,0,0,1,2,0,0,0), 8'h07, 4'd5);
    add("rel3",       0, 8'h90, tie_ids2, 8'h90, sl8(0,0,0,0,2,0,0,0), 8'h05, 4'd6);
    add("rereq3",     0, 8'h98, tie_ids2, 8'h98, sl8(0,0,0,1,2,0,0,0), 8'h07, 4'd5);
    add("flush",      1, 8'h98, tie_ids2, 8'h00, 24'd0,                8'h00, 4'd8);
    add("post_flush", 0, 8'h98, tie_ids2, 8'h88, sl8(0,0,0,1,0,0,0,0), 8'h03, 4'd6);
    add("post_flush2",0, 8'h98, tie_ids2, 8'h98, sl8(0,0,0,1,2,0,0,0), 8'h07, 4'd5);

    rst_n = 1'b0;
    flush_a = 1'b0; req_valid_a = '0; req_id_a = '0;
    flush_b = 1'b0; req_valid_b = '0; req_id_b = '0;
    #12;
    check("rst_grant_a", grant_a, 0);
    check("rst_slot_a",  slot_a,  0);
    check("rst_busy_a",  busy_a,  0);
    check("rst_free_a",  free_a,  8);
    check("rst_free_b",  free_b,  2);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      flush_a     = vecs[i].flush;
      req_valid_a = vecs[i].req_valid;
      req_id_a    = vecs[i].req_id;
      tick();
      check({vecs[i].name, "_grant"}, grant_a, vecs[i].exp_grant);
      check({vecs[i].name, "_slot"},  slot_a,  vecs[i].exp_slot);
      check({vecs[i].name, "_busy"},  busy_a,  vecs[i].exp_busy);
      check({vecs[i].name, "_free"},  free_a,  vecs[i].exp_free);
    end
    flush_a = 1'b0;

    // Asynchronous reset while three locks are held, checked before any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", grant_a, 0);
    check("async_rst_slot",  slot_a,  0);
    check("async_rst_busy",  busy_a,  0);
    check("async_rst_free",  free_a,  8);
    req_valid_a = '0;
    #2;
    rst_n = 1'b1;
    tick();
    check("after_rst_grant", grant_a, 0);

    // Full pool: younger requesters wait; a freed slot is allocatable one edge later.
    drive_b(8'h03, ids8(0, 1, 0, 0, 0, 3, 2, 0));
    tick();
    check("b_full_grant", grant_b, 8'h03);
    check("b_full_free",  free_b,  0);
    drive_b(8'h63, ids8(0, 1, 0, 0, 0, 3, 2, 0));
    tick();
    check("b_wait1_grant", grant_b, 8'h03);
    tick();
    check("b_wait2_grant", grant_b, 8'h03);
    drive_b(8'h62, ids8(0, 1, 0, 0, 0, 3, 2, 0));
    tick();
    check("b_rel_grant", grant_b, 8'h02);
    check("b_rel_free",  free_b,  1);
    check("b_rel_busy",  busy_b,  2'b10);
    tick();
    check("b_regrant_grant", grant_b, 8'h42);
    check("b_regrant_slot",  slot_b,  8'h02);
    check("b_regrant_free",  free_b,  0);
    drive_b(8'h00, '0);
    tick();
    check("b_drop_free", free_b, 2);

    // Wrap-around with one free slot: 0xFFFE is older than 0x0001.
    drive_b(8'h01, '0);
    tick();
    check("b_wrap_hold", grant_b, 8'h01);
    drive_b(8'h07, ids8(0, 'hFFFE, 'h0001, 0, 0, 0, 0, 0));
    tick();
    check("b_wrap_grant", grant_b, 8'h03);
    check("b_wrap_slot",  slot_b,  8'h02);
    tick();
    check("b_wrap_wait", grant_b, 8'h03);
    drive_b(8'h00, '0);
    tick();
    check("b_wrap_drop", grant_b, 8'h00);

    // Equal IDs on ports 3 and 4 with one free slot: lower port wins, other follows release.
    drive_b(8'h01, '0);
    tick();
    check("b_tie_hold", grant_b, 8'h01);
    drive_b(8'h19, ids8(0, 0, 0, 'h40, 'h40, 0, 0, 0));
    tick();
    check("b_tie_grant", grant_b, 8'h09);
    check("b_tie_slot",  slot_b,  8'h08);
    tick();
    check("b_tie_wait", grant_b, 8'h09);
    drive_b(8'h11, ids8(0, 0, 0, 'h40, 'h40, 0, 0, 0));
    tick();
    check("b_tie_rel_grant", grant_b, 8'h01);
    check("b_tie_rel_free",  free_b,  1);
    tick();
    check("b_tie_next_grant", grant_b, 8'h11);
    check("b_tie_next_slot",  slot_b,  8'h10);
    check("b_tie_next_free",  free_b,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
